serial_cmp_ctrl: RTL

Bit-serial magnitude-comparator controller. It latches two WIDTH-bit operands and walks them MSB-first through one external single-bit comparator cell (eq/gt/lt outputs), one bit per clock. It stops at the first differing bit and reports a registered EQ/GT/LT result with a done pulse. It sits between a requester (start/busy/done handshake) and the shared 1-bit comparator resource.

---
 rtl/serial_cmp_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/serial_cmp_ctrl.sv
// serial_cmp_ctrl
// Bit-serial magnitude-comparator controller. Latches two WIDTH-bit operands
// and walks them MSB-first through an external single-bit comparator cell.
// It stops at the first differing bit and reports a registered EQ/GT/LT
// result with a one-cycle done pulse. A non-one-hot flag set from the cell
// is reported as cmp_err.
module serial_cmp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             cmp_a,
    output logic             cmp_b,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    output logic             busy,
    output logic             done,
    output logic             A_eq_B,
    output logic             A_gt_B,
    output logic             A_lt_B,
    output logic             cmp_err
);

    // The index must be able to hold WIDTH-1; a 1-bit operand still needs a 1-bit index.
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [IDX_W-1:0] idx_r;
    logic             eq_r;
    logic             gt_r;
    logic             lt_r;
    logic             err_r;
    logic [2:0]       flags_s;

    // A healthy comparator cell raises exactly one of eq/gt/lt.
    function automatic logic is_one_hot3(input logic [2:0] v);
        is_one_hot3 = (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    assign flags_s = {cmp_eq, cmp_gt, cmp_lt};

    // Controller FSM: operand capture, MSB-first walk and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            idx_r   <= '0;
            eq_r    <= 1'b0;
            gt_r    <= 1'b0;
            lt_r    <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_r     <= A;
                        b_r     <= B;
                        idx_r   <= IDX_W'(WIDTH - 1);
                        eq_r    <= 1'b0;
                        gt_r    <= 1'b0;
                        lt_r    <= 1'b0;
                        err_r   <= 1'b0;
                        state_r <= ST_RUN;
                    end else begin
                        // DONE lasts exactly one cycle; results keep their values.
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!is_one_hot3(flags_s)) begin
                        err_r   <= 1'b1;
                        eq_r    <= 1'b0;
                        gt_r    <= 1'b0;
                        lt_r    <= 1'b0;
                        state_r <= ST_DONE;
                    end else if (cmp_gt) begin
                        gt_r    <= 1'b1;
                        state_r <= ST_DONE;
                    end else if (cmp_lt) begin
                        lt_r    <= 1'b1;
                        state_r <= ST_DONE;
                    end else if (idx_r == IDX_W'(0)) begin
                        // Last bit equal as well: operands are equal.
                        eq_r    <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        idx_r   <= idx_r - IDX_W'(1);
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Present the current bit pair to the comparator cell only while walking.
    always_comb begin
        cmp_a = 1'b0;
        cmp_b = 1'b0;
        if (state_r == ST_RUN) begin
            cmp_a = a_r[idx_r];
            cmp_b = b_r[idx_r];
        end else begin
            cmp_a = 1'b0;
            cmp_b = 1'b0;
        end
    end

    assign busy    = (state_r == ST_RUN);
    assign done    = (state_r == ST_DONE);
    assign A_eq_B  = eq_r;
    assign A_gt_B  = gt_r;
    assign A_lt_B  = lt_r;
    assign cmp_err = err_r;

endmodule
